// File: rtl/fetch_if.sv
// Bundles the fetch stage's control inputs, instruction-memory port and IF/ID outputs.
// master: the fetch stage itself. slave: the hazard/branch/memory/decode side.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic [15:0] pc_out;
  logic        fetch_halted;

  modport master (
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  imem_data,
    output imem_addr,
    output if_id_inst,
    output if_id_pc_plus2,
    output if_id_valid,
    output pc_out,
    output fetch_halted
  );

  modport slave (
    output stall,
    output redirect,
    output redirect_pc,
    output imem_data,
    input  imem_addr,
    input  if_id_inst,
    input  if_id_pc_plus2,
    input  if_id_valid,
    input  pc_out,
    input  fetch_halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, fills the IF/ID register
// and freezes on HLT until a redirect arrives.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] BUBBLE_INST = 16'h0000
) (
  input logic   clk,
  input logic   rst,
  fetch_if.master bus
);

  typedef enum logic [0:0] {StFetch, StHalted} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] inst_q, inst_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic        valid_q, valid_d;
  logic [15:0] pc_plus2;
  logic        is_halt;

  assign pc_plus2 = pc_q + 16'd2;
  assign is_halt  = (bus.imem_data[15:12] == HALT_OPCODE);

  // Priority: redirect > stall > HLT detection > normal increment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (bus.redirect) begin
      state_d    = StFetch;
      pc_d       = {bus.redirect_pc[15:1], 1'b0};
      inst_d     = BUBBLE_INST;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (!bus.stall) begin
      unique case (state_q)
        StFetch: begin
          inst_d     = bus.imem_data;
          pc_plus2_d = pc_plus2;
          valid_d    = 1'b1;
          if (is_halt) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_plus2;
          end
        end
        StHalted: begin
          inst_d  = BUBBLE_INST;
          valid_d = 1'b0;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      inst_q     <= BUBBLE_INST;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.pc_out         = pc_q;
  assign bus.if_id_inst     = inst_q;
  assign bus.if_id_pc_plus2 = pc_plus2_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_halted   = (state_q == StHalted);

endmodule
